// File: rtl/binary_down_timer_par_load.sv
// Parameterised binary down-counter/timer with parallel load, one-shot or
// auto-reload at terminal count, combinational borrow and registered status.
module binary_down_timer_par_load #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             CLK,
   input  logic             Clear_b,
   input  logic [WIDTH-1:0] Data_in,
   input  logic             Load,
   input  logic             Count,
   input  logic             Reload_en,
   output logic [WIDTH-1:0] A_count,
   output logic             B_out,
   output logic             Busy,
   output logic             Done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             at_zero;

   assign at_zero = (count_q == '0);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (Load) begin
         count_d  = Data_in;
         reload_d = Data_in;
         state_d  = ST_RUN;
      end else if ((state_q == ST_RUN) && Count) begin
         if (!at_zero) begin
            count_d = count_q - 1'b1;
         end else begin
            // Terminal event: zero never wraps, it reloads or parks in HOLD.
            done_d = 1'b1;
            if (Reload_en) begin
               count_d = reload_q;
            end else begin
               state_d = ST_HOLD;
            end
         end
      end
      busy_d = (state_d == ST_RUN);
   end

   always_ff @(posedge CLK or negedge Clear_b) begin
      if (!Clear_b) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         reload_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign A_count = count_q;
   assign Busy    = busy_q;
   assign Done    = done_q;
   assign B_out   = Count & ~Load & busy_q & at_zero;

endmodule

// File: tb/tb_binary_down_timer_par_load.sv
// Scoreboard bench for binary_down_timer_par_load: directed scenarios then
// random stimulus against a behavioural timer model.
module tb_binary_down_timer_par_load;

   localparam int unsigned WIDTH = 4;

   logic             CLK = 1'b0;
   logic             Clear_b;
   logic [WIDTH-1:0] Data_in;
   logic             Load;
   logic             Count;
   logic             Reload_en;
   logic [WIDTH-1:0] A_count;
   logic             B_out;
   logic             Busy;
   logic             Done;

   binary_down_timer_par_load #(.WIDTH(WIDTH)) dut (
      .CLK      (CLK),
      .Clear_b  (Clear_b),
      .Data_in  (Data_in),
      .Load     (Load),
      .Count    (Count),
      .Reload_en(Reload_en),
      .A_count  (A_count),
      .B_out    (B_out),
      .Busy     (Busy),
      .Done     (Done)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [WIDTH-1:0] cnt;
      logic             busy;
      logic             done;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Behavioural model: a timer that is either running or parked.
   bit   m_running = 0;
   int   m_cnt = 0;
   int   m_rel = 0;
   bit   m_done = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every edge the DUT presents new registered outputs.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("A_count", int'(A_count), int'(e.cnt));
            chk("Busy", int'(Busy), int'(e.busy));
            chk("Done", int'(Done), int'(e.done));
         end
      end
   end

   task automatic step(input bit ld, input bit cn, input bit rl, input int d);
      exp_t e;
      @(negedge CLK);
      Load      = ld;
      Count     = cn;
      Reload_en = rl;
      Data_in   = d[WIDTH-1:0];
      #1;
      chk("B_out", int'(B_out), int'(cn && !ld && m_running && m_cnt == 0));
      if (ld) begin
         m_cnt     = d % (1 << WIDTH);
         m_rel     = m_cnt;
         m_running = 1;
         m_done    = 0;
      end else if (m_running && cn) begin
         if (m_cnt > 0) begin
            m_cnt  = m_cnt - 1;
            m_done = 0;
         end else begin
            m_done = 1;
            if (rl) m_cnt = m_rel;
            else    m_running = 0;
         end
      end else begin
         m_done = 0;
      end
      e.cnt  = m_cnt[WIDTH-1:0];
      e.busy = m_running;
      e.done = m_done;
      exp_q.push_back(e);
   endtask

   task automatic reset_mid_cycle();
      exp_t e;
      @(negedge CLK);
      #2;
      Clear_b = 1'b0;
      #1;
      chk("rst A_count", int'(A_count), 0);
      chk("rst Busy", int'(Busy), 0);
      chk("rst Done", int'(Done), 0);
      chk("rst B_out", int'(B_out), 0);
      m_running = 0;
      m_cnt     = 0;
      m_rel     = 0;
      m_done    = 0;
      e = '0;
      exp_q.push_back(e);
      @(posedge CLK);
      #2;
      Clear_b = 1'b1;
   endtask

   initial begin
      int n;
      Clear_b   = 1'b0;
      Load      = 1'b0;
      Count     = 1'b1;
      Reload_en = 1'b0;
      Data_in   = '0;
      #12;
      chk("init A_count", int'(A_count), 0);
      chk("init Busy", int'(Busy), 0);
      chk("init B_out", int'(B_out), 0);
      Clear_b = 1'b1;

      // Reset values: Count alone does nothing.
      reset_mid_cycle();
      repeat (3) step(0, 1, 0, 0);
      // One-shot from A.
      step(1, 0, 0, 'hA);
      repeat (14) step(0, 1, 0, 0);
      // Auto-reload from 3.
      step(1, 0, 1, 3);
      repeat (9) step(0, 1, 1, 0);
      // Load beats Count, then pause at 3.
      step(1, 1, 0, 5);
      repeat (2) step(0, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0);
      repeat (5) step(0, 1, 0, 0);
      // Reset mid-run at 6, then Count alone is ignored.
      step(1, 0, 0, 8);
      repeat (2) step(0, 1, 0, 0);
      reset_mid_cycle();
      repeat (3) step(0, 1, 0, 0);
      // Zero load with reload: terminal every counted cycle.
      step(1, 0, 1, 0);
      repeat (5) step(0, 1, 1, 0);
      step(0, 0, 1, 0);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) < 2) begin
            reset_mid_cycle();
         end else begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
         end
      end

      n = 0;
      while (exp_q.size() > 0 && n < 10) begin
         @(posedge CLK);
         n++;
      end
      #2;
      chk("scoreboard drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
